// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command receiver.
// Holds the receiver state encoding, the ASCII digit window and bit-timing helpers.
// Pure declarations: no logic, no latency.
package uart_cmd_pkg;

  // Receiver frame state. The encoding is only visible inside the receiver and the bench.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    DONE      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Accepted command characters are the ASCII digits '0'..'9'.
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  // Timer value at the middle of a bit, measured from the start-bit falling edge.
  function automatic int mid_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

  // True when the received byte is one of the command digits.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to 1 (idle-high lines).
// Latency: 2 clk from d to q.
// No backpressure: free-running, samples d every cycle.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state: shift the async input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Register both stages; reset to the idle-high level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that decodes ASCII '0'..'9' into a 4-bit command code with a one-cycle rx_rdy.
// Latency: rx_rdy about 9.5 bit times + 4 clk after the start-bit falling edge on rxd.
// No backpressure: each frame produces its strobes once; rx_out holds until the next valid command.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [3:0] rx_out,
  output logic       rx_rdy,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_err
);

  import uart_cmd_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_bit(CLKS_PER_BIT));

  // Synchronised copy of the line; the raw rxd is never used past this point.
  logic rxs;

  sync_2ff u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [3:0]       rx_out_q, rx_out_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             cmd_err_q, cmd_err_d;
  logic             cnt_at_last;
  logic             cnt_at_mid;

  assign cnt_at_last = (cnt_q == CNT_LAST);
  assign cnt_at_mid  = (cnt_q == CNT_MID);

  // Frame FSM, bit timer, shifter and output strobes; defaults hold state and keep strobes low.
  always_comb begin
    state_d     = state_q;
    // Timer saturates at its terminal value; every state transition below clears it.
    cnt_d       = cnt_at_last ? cnt_q : cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_out_d    = rx_out_q;
    rx_byte_d   = rx_byte_q;
    rx_rdy_d    = 1'b0;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end

      START: begin
        // Re-check the line in the middle of the start bit to reject short glitches.
        if (cnt_at_mid) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end

      DATA: begin
        // A full bit period after the mid-start sample lands in the middle of each data bit.
        if (cnt_at_last) begin
          cnt_d            = '0;
          shreg_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt_at_last) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end

      DONE: begin
        cnt_d      = '0;
        rx_byte_d  = shreg_q;
        rx_valid_d = 1'b1;
        if (is_digit(shreg_q)) begin
          // For '0'..'9' the low nibble of the ASCII code is already the digit value.
          rx_out_d = shreg_q[3:0];
          rx_rdy_d = 1'b1;
        end else begin
          cmd_err_d = 1'b1;
        end
        state_d = IDLE;
      end

      WAIT_HIGH: begin
        // Line held low (break or stuck line): wait for idle before arming for a new start.
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: state, bit timer, bit index and the receive shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Output registers: held command/byte values and the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_out_q    <= 4'h0;
      rx_byte_q   <= 8'h00;
      rx_rdy_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      rx_out_q    <= rx_out_d;
      rx_byte_q   <= rx_byte_d;
      rx_rdy_q    <= rx_rdy_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign rx_out    = rx_out_q;
  assign rx_rdy    = rx_rdy_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a scoreboard of expected received bytes.
// Bit period is 16 clk; outputs are sampled on the falling clock edge.
// Expected results are queued when a frame is sent and popped when rx_valid fires.
module tb_uart_cmd_rx;

  import uart_cmd_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [3:0] rx_out;
  logic       rx_rdy;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_err;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_out    (rx_out),
    .rx_rdy    (rx_rdy),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] byte_v;
    logic       rdy;
    logic       cerr;
    logic [3:0] out;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0, valid_cnt = 0, fe_cnt = 0, ce_cnt = 0;
  int exp_rdy = 0, exp_valid = 0, exp_fe = 0, exp_ce = 0;
  logic [3:0] model_out = 4'h0;
  logic [3:0] prev_out = 4'h0;
  logic       prev_rdy = 1'b0;
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard and strobe monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rx_rdy)    rdy_cnt++;
      if (rx_valid)  valid_cnt++;
      if (frame_err) fe_cnt++;
      if (cmd_err)   ce_cnt++;
      if (rx_valid) begin
        chk("valid_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rx_byte", rx_byte, e.byte_v);
          chk("rx_rdy_with_valid", rx_rdy, e.rdy);
          chk("cmd_err_with_valid", cmd_err, e.cerr);
          chk("rx_out", rx_out, e.out);
          chk("frame_err_with_valid", frame_err, 1'b0);
        end
      end
      if (rx_out !== prev_out) chk("rx_out_changes_only_on_rdy", rx_rdy, 1'b1);
      if (rx_rdy) chk("rx_rdy_one_cycle", prev_rdy, 1'b0);
    end
    prev_out = rx_out;
    prev_rdy = rx_rdy;
  end

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop_v, CPB);
    rxd = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.byte_v = b;
    if (b >= 8'h30 && b <= 8'h39) begin
      model_out = b[3:0];
      e.rdy  = 1'b1;
      e.cerr = 1'b0;
      exp_rdy++;
    end else begin
      e.rdy  = 1'b0;
      e.cerr = 1'b1;
      exp_ce++;
    end
    e.out = model_out;
    exp_valid++;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    expect_byte(b);
    send_frame(b, 1'b1);
  endtask

  task automatic drain_and_count(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_rdy_cnt"}, rdy_cnt, exp_rdy);
    chk({tag, "_valid_cnt"}, valid_cnt, exp_valid);
    chk({tag, "_fe_cnt"}, fe_cnt, exp_fe);
    chk({tag, "_ce_cnt"}, ce_cnt, exp_ce);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_out", rx_out, 4'h0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_rx_rdy", rx_rdy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    prev_out = rx_out;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Single digit '1'
    send_byte(8'h31);
    drain_and_count("digit1");
    chk("digit1_out", rx_out, 4'h1);

    // Back-to-back '7' then '0' with no idle gap
    send_byte(8'h37);
    chk("b2b_out_7", rx_out, 4'h7);
    send_byte(8'h30);
    drain_and_count("b2b");
    chk("b2b_out_0", rx_out, 4'h0);
    repeat (10) @(negedge clk);

    // Non-digit 'A' keeps the previous command
    send_byte(8'h35);
    send_byte(8'h41);
    drain_and_count("nondigit");
    chk("nondigit_out_kept", rx_out, 4'h5);
    chk("nondigit_byte", rx_byte, 8'h41);
    repeat (10) @(negedge clk);

    // Stop bit low, line held low, then released
    exp_fe++;
    send_frame(8'h36, 1'b0);
    rxd = 1'b0;
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 20);
    drain_and_count("framing");
    chk("framing_state", 32'(dut.state_q), 32'(IDLE));
    send_byte(8'h34);
    drain_and_count("after_break");
    chk("after_break_out", rx_out, 4'h4);
    repeat (10) @(negedge clk);

    // Short low glitch on an idle line
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 30);
    drain_and_count("glitch");
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
    send_byte(8'h32);
    drain_and_count("after_glitch");
    chk("after_glitch_out", rx_out, 4'h2);
    repeat (10) @(negedge clk);

    // Reset in the middle of data bit 3 of '8'; the sender abandons the frame too
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB / 2);
    chk("pre_rst_state", 32'(dut.state_q), 32'(DATA));
    mon_en = 1'b0;
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rx_out", rx_out, 4'h0);
    chk("midrst_rx_byte", rx_byte, 8'h00);
    chk("midrst_rx_rdy", rx_rdy, 1'b0);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    chk("midrst_cmd_err", cmd_err, 1'b0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    model_out = 4'h0;
    prev_out = rx_out;
    mon_en = 1'b1;
    repeat (40) @(negedge clk);
    drain_and_count("midrst");
    send_byte(8'h39);
    drain_and_count("after_rst");
    chk("after_rst_out", rx_out, 4'h9);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
